// File: rtl/aurora_pkg.sv
// Aurora 8B/10B TX ordered-set definitions: set encodings, symbol constants and set contents.
package aurora_pkg;

    localparam int unsigned SYM_W      = 9;
    localparam int unsigned OS_MAX_LEN = 4;

    typedef enum logic [3:0] {
        OS_I   = 4'd0,
        OS_SP  = 4'd1,
        OS_SPA = 4'd2,
        OS_VER = 4'd3,
        OS_SCP = 4'd4,
        OS_ECP = 4'd5,
        OS_P   = 4'd6,
        OS_SUF = 4'd7,
        OS_K   = 4'd8,
        OS_R   = 4'd9,
        OS_A   = 4'd10,
        OS_CC  = 4'd11,
        OS_SNF = 4'd12
    } ordered_sets_e;

    typedef struct packed {
        logic       k;
        logic [7:0] data;
    } sym_t;

    typedef sym_t [OS_MAX_LEN-1:0] os_syms_t;

    localparam logic [7:0] SYM_K28_5 = 8'hBC;
    localparam logic [7:0] SYM_K28_0 = 8'h1C;
    localparam logic [7:0] SYM_K28_3 = 8'h7C;
    localparam logic [7:0] SYM_K28_2 = 8'h5C;
    localparam logic [7:0] SYM_K28_4 = 8'h9C;
    localparam logic [7:0] SYM_K28_6 = 8'hDC;
    localparam logic [7:0] SYM_K27_7 = 8'hFB;
    localparam logic [7:0] SYM_K29_7 = 8'hFD;
    localparam logic [7:0] SYM_K30_7 = 8'hFE;
    localparam logic [7:0] SYM_K23_7 = 8'hF7;
    localparam logic [7:0] SYM_D10_2 = 8'h4A;
    localparam logic [7:0] SYM_D12_1 = 8'h2C;
    localparam logic [7:0] SYM_D8_7  = 8'hE8;

    function automatic sym_t kc(input logic [7:0] d);
        return '{k: 1'b1, data: d};
    endfunction

    function automatic sym_t dc(input logic [7:0] d);
        return '{k: 1'b0, data: d};
    endfunction

    // Number of symbols in a set; undefined encodings count as an idle request.
    function automatic logic [2:0] os_length(input ordered_sets_e t);
        case (t)
            OS_SP, OS_SPA, OS_VER:                      return 3'd4;
            OS_SCP, OS_ECP, OS_CC:                      return 3'd2;
            OS_P, OS_SUF, OS_K, OS_R, OS_A, OS_SNF:     return 3'd1;
            default:                                    return 3'd0;
        endcase
    endfunction

    // Set contents, slot 0 first.
    function automatic os_syms_t os_symbols(input ordered_sets_e t);
        os_syms_t s;
        s = '0;
        case (t)
            OS_SP:  begin
                s[0] = kc(SYM_K28_5); s[1] = dc(SYM_D10_2);
                s[2] = dc(SYM_D10_2); s[3] = dc(SYM_D10_2);
            end
            OS_SPA: begin
                s[0] = kc(SYM_K28_5); s[1] = dc(SYM_D12_1);
                s[2] = dc(SYM_D12_1); s[3] = dc(SYM_D12_1);
            end
            OS_VER: begin
                s[0] = kc(SYM_K28_5); s[1] = dc(SYM_D8_7);
                s[2] = dc(SYM_D8_7);  s[3] = dc(SYM_D8_7);
            end
            OS_SCP: begin s[0] = kc(SYM_K28_2); s[1] = kc(SYM_K27_7); end
            OS_ECP: begin s[0] = kc(SYM_K29_7); s[1] = kc(SYM_K30_7); end
            OS_CC:  begin s[0] = kc(SYM_K23_7); s[1] = kc(SYM_K23_7); end
            OS_P, OS_SUF: s[0] = kc(SYM_K28_4);
            OS_K:   s[0] = kc(SYM_K28_5);
            OS_R:   s[0] = kc(SYM_K28_0);
            OS_A:   s[0] = kc(SYM_K28_3);
            OS_SNF: s[0] = kc(SYM_K28_6);
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/aurora_idle_gen.sv
// Pseudo-random Aurora idle symbols (/K/, /R/, /A/) driven by a 7-bit LFSR and an /A/ spacing counter.
module aurora_idle_gen
    import aurora_pkg::*;
#(
    parameter int unsigned SYMS      = 2,
    parameter logic [6:0]  LFSR_SEED = 7'h5A,
    parameter int unsigned A_MIN     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SYMS-1:0]  idle_mask_i,
    output sym_t [SYMS-1:0]  idle_sym_c_o
);

    localparam int unsigned ACW = $clog2(A_MIN + 16);

    logic [6:0]     lfsr_q, lfsr_d;
    logic [ACW-1:0] a_cnt_q, a_cnt_d;
    logic           send_a;

    always_comb begin
        send_a  = (&idle_mask_i) && (a_cnt_q == '0);
        lfsr_d  = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        a_cnt_d = a_cnt_q;
        if (send_a) begin
            a_cnt_d = ACW'(A_MIN) + ACW'(lfsr_q[3:0]);
        end else if (a_cnt_q != '0) begin
            a_cnt_d = a_cnt_q - ACW'(1);
        end
        for (int s = 0; s < int'(SYMS); s++) begin
            idle_sym_c_o[s] = lfsr_q[s] ? kc(SYM_K28_5) : kc(SYM_K28_0);
        end
        // /A/ only ever replaces slot 0 of a fully idle cycle.
        if (send_a) begin
            idle_sym_c_o[0] = kc(SYM_K28_3);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q  <= LFSR_SEED;
            a_cnt_q <= ACW'(A_MIN);
        end else begin
            lfsr_q  <= lfsr_d;
            a_cnt_q <= a_cnt_d;
        end
    end

endmodule

// File: rtl/ordered_sets_sequencer.sv
// Aurora TX ordered-set sequencer: splits accepted sets across SYMS-wide cycles and fills free slots with idles.
module ordered_sets_sequencer
    import aurora_pkg::*;
#(
    parameter int unsigned SYMS      = 2,
    parameter logic [6:0]  LFSR_SEED = 7'h5A,
    parameter int unsigned A_MIN     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                os_valid,
    input  ordered_sets_e       os_type,
    output logic                os_ready,
    output logic [SYMS*8-1:0]   sym_data,
    output logic [SYMS-1:0]     sym_k,
    output logic                busy
);

    os_syms_t        buf_q, buf_d, src;
    logic [2:0]      left_q, left_d, src_len, n_sym;
    logic            accept;
    logic            busy_q, busy_d;
    logic [SYMS-1:0] idle_mask;
    sym_t [SYMS-1:0] idle_sym, out_d, out_q;

    assign os_ready = rst_n && (left_q == '0);
    assign accept   = os_valid && os_ready;

    // Pick the symbol source for the next output cycle and advance the buffer.
    always_comb begin
        src     = buf_q;
        src_len = left_q;
        if (left_q == '0) begin
            src     = os_symbols(os_type);
            src_len = accept ? os_length(os_type) : 3'd0;
        end
        n_sym = (src_len > 3'(SYMS)) ? 3'(SYMS) : src_len;
        for (int s = 0; s < int'(SYMS); s++) begin
            idle_mask[s] = (3'(s) >= n_sym);
        end
        buf_d  = src >> (SYM_W * SYMS);
        left_d = src_len - n_sym;
        busy_d = (left_d != '0);
    end

    always_comb begin
        for (int s = 0; s < int'(SYMS); s++) begin
            out_d[s] = idle_mask[s] ? idle_sym[s] : src[s];
        end
    end

    aurora_idle_gen #(
        .SYMS      (SYMS),
        .LFSR_SEED (LFSR_SEED),
        .A_MIN     (A_MIN)
    ) u_idle_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .idle_mask_i  (idle_mask),
        .idle_sym_c_o (idle_sym)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_q  <= '0;
            left_q <= '0;
            out_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            left_q <= left_d;
            out_q  <= out_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        for (int s = 0; s < int'(SYMS); s++) begin
            sym_data[8*s +: 8] = out_q[s].data;
            sym_k[s]           = out_q[s].k;
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_ordered_sets_sequencer.sv
// Bench for ordered_sets_sequencer at SYMS=1,2,4 against a queue-style reference model.
module tb_ordered_sets_sequencer;
    import aurora_pkg::*;

    localparam logic [6:0] SEED  = 7'h5A;
    localparam int         AMIN  = 16;
    localparam int         SY [3] = '{1, 2, 4};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vld [3];
    ordered_sets_e typ [3];
    logic          rdy [3];
    logic          bsy [3];
    logic [7:0]    d0;
    logic [15:0]   d1;
    logic [31:0]   d2;
    logic [0:0]    k0;
    logic [1:0]    k1;
    logic [3:0]    k2;

    always #5 clk = ~clk;

    ordered_sets_sequencer #(.SYMS(1), .LFSR_SEED(SEED), .A_MIN(AMIN)) u_s1 (
        .clk(clk), .rst_n(rst_n), .os_valid(vld[0]), .os_type(typ[0]), .os_ready(rdy[0]),
        .sym_data(d0), .sym_k(k0), .busy(bsy[0]));
    ordered_sets_sequencer #(.SYMS(2), .LFSR_SEED(SEED), .A_MIN(AMIN)) u_s2 (
        .clk(clk), .rst_n(rst_n), .os_valid(vld[1]), .os_type(typ[1]), .os_ready(rdy[1]),
        .sym_data(d1), .sym_k(k1), .busy(bsy[1]));
    ordered_sets_sequencer #(.SYMS(4), .LFSR_SEED(SEED), .A_MIN(AMIN)) u_s4 (
        .clk(clk), .rst_n(rst_n), .os_valid(vld[2]), .os_type(typ[2]), .os_ready(rdy[2]),
        .sym_data(d2), .sym_k(k2), .busy(bsy[2]));

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [8:0]  mbuf [3][8];
    int          mcnt [3];
    logic [6:0]  mlfsr [3];
    int          ma [3];
    logic [31:0] ed [3];
    logic [3:0]  ek [3];
    logic        eb [3];

    function automatic int os_len(input ordered_sets_e t);
        case (t)
            OS_SP, OS_SPA, OS_VER:                  return 4;
            OS_SCP, OS_ECP, OS_CC:                  return 2;
            OS_P, OS_SUF, OS_K, OS_R, OS_A, OS_SNF: return 1;
            default:                                return 0;
        endcase
    endfunction

    function automatic logic [8:0] os_sym(input ordered_sets_e t, input int i);
        logic [8:0] a [4];
        a = '{9'h000, 9'h000, 9'h000, 9'h000};
        case (t)
            OS_SP:        a = '{9'h1BC, 9'h04A, 9'h04A, 9'h04A};
            OS_SPA:       a = '{9'h1BC, 9'h02C, 9'h02C, 9'h02C};
            OS_VER:       a = '{9'h1BC, 9'h0E8, 9'h0E8, 9'h0E8};
            OS_SCP:       a = '{9'h15C, 9'h1FB, 9'h000, 9'h000};
            OS_ECP:       a = '{9'h1FD, 9'h1FE, 9'h000, 9'h000};
            OS_CC:        a = '{9'h1F7, 9'h1F7, 9'h000, 9'h000};
            OS_P, OS_SUF: a = '{9'h19C, 9'h000, 9'h000, 9'h000};
            OS_K:         a = '{9'h1BC, 9'h000, 9'h000, 9'h000};
            OS_R:         a = '{9'h11C, 9'h000, 9'h000, 9'h000};
            OS_A:         a = '{9'h17C, 9'h000, 9'h000, 9'h000};
            OS_SNF:       a = '{9'h1DC, 9'h000, 9'h000, 9'h000};
            default:      a = '{9'h000, 9'h000, 9'h000, 9'h000};
        endcase
        return a[i];
    endfunction

    // One clock of the reference: pending-symbol list drained SYMS at a time, idles fill the rest.
    task automatic model_step(input int i);
        int         n;
        logic [8:0] sym;
        logic       reload;
        if (!rst_n) begin
            mcnt[i] = 0; mlfsr[i] = SEED; ma[i] = AMIN;
            ed[i] = '0; ek[i] = '0; eb[i] = 1'b0;
            return;
        end
        if (mcnt[i] == 0 && vld[i]) begin
            for (int j = 0; j < os_len(typ[i]); j++) mbuf[i][j] = os_sym(typ[i], j);
            mcnt[i] = os_len(typ[i]);
        end
        n = (mcnt[i] < SY[i]) ? mcnt[i] : SY[i];
        reload = 1'b0; ed[i] = '0; ek[i] = '0;
        for (int s = 0; s < SY[i]; s++) begin
            if (s < n) sym = mbuf[i][s];
            else if (n == 0 && s == 0 && ma[i] == 0) begin sym = 9'h17C; reload = 1'b1; end
            else sym = mlfsr[i][s] ? 9'h1BC : 9'h11C;
            ed[i][8*s +: 8] = sym[7:0];
            ek[i][s]        = sym[8];
        end
        for (int j = 0; j < mcnt[i] - n; j++) mbuf[i][j] = mbuf[i][j+n];
        mcnt[i] = mcnt[i] - n;
        if (reload) ma[i] = AMIN + int'(mlfsr[i][3:0]);
        else if (ma[i] > 0) ma[i] = ma[i] - 1;
        mlfsr[i] = {mlfsr[i][5:0], mlfsr[i][6] ^ mlfsr[i][5]};
        eb[i] = (mcnt[i] != 0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [31:0] od [3];
        logic [31:0] ok [3];
        for (int i = 0; i < 3; i++) model_step(i);
        @(posedge clk);
        #1;
        cyc++;
        od[0] = 32'(d0); od[1] = 32'(d1); od[2] = d2;
        ok[0] = 32'(k0); ok[1] = 32'(k1); ok[2] = 32'(k2);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("data_s%0d@%0d", SY[i], cyc), od[i], ed[i]);
            chk($sformatf("k_s%0d@%0d", SY[i], cyc), ok[i], 32'(ek[i]));
            chk($sformatf("ready_s%0d@%0d", SY[i], cyc), 32'(rdy[i]), 32'(rst_n && mcnt[i] == 0));
            chk($sformatf("busy_s%0d@%0d", SY[i], cyc), 32'(bsy[i]), 32'(eb[i]));
        end
    endtask

    initial begin
        int          last_a;
        int          n_a;
        logic [31:0] rec [40];

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin vld[i] = 1'b0; typ[i] = OS_I; end
        tick(); tick();
        chk("rst_data", 32'(d1), 32'h0);
        chk("rst_ready", 32'(rdy[1]), 32'h0);
        rst_n = 1'b1;
        repeat (3) tick();

        // SYMS=1, SP over four cycles
        chk("t1_ready_pre", 32'(rdy[0]), 32'h1);
        vld[0] = 1'b1; typ[0] = OS_SP;
        tick();
        vld[0] = 1'b0;
        chk("t1_sym0", 32'(d0), 32'hBC);
        chk("t1_k0", 32'(k0), 32'h1);
        chk("t1_ready0", 32'(rdy[0]), 32'h0);
        for (int j = 1; j < 4; j++) begin
            tick();
            chk("t1_symn", 32'(d0), 32'h4A);
            chk("t1_kn", 32'(k0), 32'h0);
            chk("t1_readyn", 32'(rdy[0]), 32'(j == 3));
        end

        // SYMS=4, SP in a single cycle
        vld[2] = 1'b1; typ[2] = OS_SP;
        tick();
        vld[2] = 1'b0;
        chk("t2_data", d2, 32'h4A4A4ABC);
        chk("t2_k", 32'(k2), 32'h1);
        chk("t2_busy", 32'(bsy[2]), 32'h0);

        // SYMS=4, SCP with idle tail
        vld[2] = 1'b1; typ[2] = OS_SCP;
        tick();
        vld[2] = 1'b0;
        chk("t3_lo", 32'(d2[15:0]), 32'hFB5C);
        chk("t3_k", 32'(k2), 32'hF);
        chk("t3_s2", 32'(d2[23:16] == 8'hBC || d2[23:16] == 8'h1C), 32'h1);
        chk("t3_s3", 32'(d2[31:24] == 8'hBC || d2[31:24] == 8'h1C), 32'h1);
        tick();
        chk("t3_after_k", 32'(k2), 32'hF);

        // SYMS=2, SPA then CC back to back
        vld[1] = 1'b1; typ[1] = OS_SPA;
        tick();
        chk("t4_c0", 32'(d1), 32'h2CBC);
        chk("t4_k0", 32'(k1), 32'h1);
        typ[1] = OS_CC;
        tick();
        chk("t4_c1", 32'(d1), 32'h2C2C);
        chk("t4_k1", 32'(k1), 32'h0);
        tick();
        vld[1] = 1'b0;
        chk("t4_c2", 32'(d1), 32'hF7F7);
        chk("t4_k2", 32'(k1), 32'h3);

        // Long idle stretch: /A/ placement and spacing
        last_a = -1; n_a = 0;
        repeat (200) begin
            tick();
            chk("t5_slot1", 32'(d1[15:8] == 8'hBC || d1[15:8] == 8'h1C), 32'h1);
            if (d1[7:0] == 8'h7C) begin
                if (last_a >= 0) chk("t5_gap", 32'(cyc - last_a >= 17 && cyc - last_a <= 32), 32'h1);
                last_a = cyc;
                n_a++;
            end
        end
        chk("t5_a_count", 32'(n_a >= 5), 32'h1);

        // Idle sequence repeats after reset with the same seed
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int j = 0; j < 40; j++) begin tick(); rec[j] = ed[2]; end
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int j = 0; j < 40; j++) begin tick(); chk("t5_repeat", d2, rec[j]); end

        // SYMS=1, reset during VER symbol 2
        vld[0] = 1'b1; typ[0] = OS_VER;
        tick();
        vld[0] = 1'b0;
        tick();
        chk("t6_sym1", 32'(d0), 32'hE8);
        rst_n = 1'b0;
        tick();
        chk("t6_rst_data", 32'(d0), 32'h0);
        chk("t6_rst_k", 32'(k0), 32'h0);
        chk("t6_rst_ready", 32'(rdy[0]), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("t6_seed_s1", 32'(d0), 32'h1C);
        chk("t6_seed_s2", 32'(d1), 32'hBC1C);
        chk("t6_seed_s4", d2, 32'hBC1CBC1C);

        // Randomised traffic, undefined encodings and sporadic resets
        repeat (400) begin
            for (int i = 0; i < 3; i++) begin
                vld[i] = 1'($urandom_range(0, 1));
                typ[i] = ordered_sets_e'(4'($urandom_range(0, 15)));
            end
            rst_n = ($urandom_range(0, 63) != 0);
            tick();
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) vld[i] = 1'b0;
        repeat (6) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
